// File: rtl/adc_pkt_pkg.sv
// adc_pkt_pkg
//   Shared types and constants for the ADC packet framer: FSM state encoding,
//   header tag, default data widths and the payload-length decode.
package adc_pkt_pkg;

   localparam int         DW_IN_DEF  = 36;
   localparam int         DW_OUT_DEF = 18;
   localparam logic [1:0] HDR_TAG    = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_TRL,
      ST_GAP
   } state_t;

   // Payload words per packet for a 2-bit length code.
   function automatic int unsigned len_decode(input int unsigned base, input logic [1:0] code);
      return base << code;
   endfunction

endpackage

// File: rtl/adc_pkt_framer.sv
// adc_pkt_framer
//   Splits 36-bit captured words into 18-bit beats and frames them as
//   header / payload / XOR-checksum trailer, followed by an idle gap.
//   DW_IN must equal 2*DW_OUT.
//
// Ports:
//   pktctrl_clk         packet clock
//   pktctrl_rst         asynchronous active-high reset
//   rf_pkt_en           level enable (already in pktctrl_clk domain)
//   rf_pkt_data_length  payload words = LEN_BASE << value
//   rf_pkt_idle_length  idle cycles between packets
//   in_data/in_valid    captured word, [DW_IN-1:DW_OUT] is the first sample
//   in_ready            word accepted when in_valid & in_ready
//   ADC_DATA            beat to the pads
//   ADC_DATA_VALID      ADC_DATA qualifier
//   pkt_busy            high outside IDLE
//   pkt_done            one-cycle pulse with the trailer beat
module adc_pkt_framer
   import adc_pkt_pkg::*;
#(
   parameter int DW_IN    = DW_IN_DEF,
   parameter int DW_OUT   = DW_OUT_DEF,
   parameter int LEN_BASE = 256
) (
   input  logic              pktctrl_clk,
   input  logic              pktctrl_rst,
   input  logic              rf_pkt_en,
   input  logic [1:0]        rf_pkt_data_length,
   input  logic [15:0]       rf_pkt_idle_length,
   input  logic [DW_IN-1:0]  in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DW_OUT-1:0] ADC_DATA,
   output logic              ADC_DATA_VALID,
   output logic              pkt_busy,
   output logic              pkt_done
);

   // Wide enough for the largest length code without wrapping.
   localparam int CNT_W = $clog2(LEN_BASE * 8);

   state_t              r_state, w_state_nxt;
   logic [DW_OUT-1:0]   r_data,  w_data_nxt;
   logic                r_vld,   w_vld_nxt;
   logic                r_done,  w_done_nxt;
   logic [15:0]         r_seq,   w_seq_nxt;
   logic [DW_OUT-1:0]   r_csum,  w_csum_nxt;
   logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
   logic [15:0]         r_gap,   w_gap_nxt;
   logic [DW_OUT-1:0]   r_lo,    w_lo_nxt;
   logic [1:0]          r_len,   w_len_nxt;
   logic [15:0]         r_idle,  w_idle_nxt;
   logic [CNT_W-1:0]    w_last;
   logic [DW_OUT-1:0]   w_hi;
   logic                w_start;

   assign w_last = CNT_W'(len_decode(LEN_BASE, r_len) - 1);
   assign w_hi   = in_data[DW_IN-1:DW_OUT];

   assign in_ready       = (r_state == ST_DATA_HI);
   assign pkt_busy       = (r_state != ST_IDLE);
   assign ADC_DATA       = r_data;
   assign ADC_DATA_VALID = r_vld;
   assign pkt_done       = r_done;

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_vld_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_seq_nxt   = r_seq;
      w_csum_nxt  = r_csum;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_lo_nxt    = r_lo;
      w_len_nxt   = r_len;
      w_idle_nxt  = r_idle;
      w_start     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (rf_pkt_en) begin
               w_start = 1'b1;
            end else begin
               w_seq_nxt  = '0;
               w_data_nxt = '0;
            end
         end
         ST_DATA_HI: begin
            // No input word: bubble, ADC_DATA keeps the last beat.
            if (in_valid) begin
               w_data_nxt  = w_hi;
               w_vld_nxt   = 1'b1;
               w_lo_nxt    = in_data[DW_OUT-1:0];
               w_csum_nxt  = r_csum ^ w_hi;
               w_state_nxt = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            w_data_nxt  = r_lo;
            w_vld_nxt   = 1'b1;
            w_csum_nxt  = r_csum ^ r_lo;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = (r_cnt == w_last) ? ST_TRL : ST_DATA_HI;
         end
         ST_TRL: begin
            w_data_nxt = r_csum;
            w_vld_nxt  = 1'b1;
            w_done_nxt = 1'b1;
            w_seq_nxt  = r_seq + 16'd1;
            // A zero-length gap with enable high passes through GAP with a
            // zero count, so the next header lands on the very next edge
            // without pkt_busy dropping.
            if ((r_idle != 16'd0) || rf_pkt_en) begin
               w_gap_nxt   = r_idle;
               w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            w_data_nxt = '0;
            if (r_gap != 16'd0) begin
               w_gap_nxt = r_gap - 16'd1;
            end else if (rf_pkt_en) begin
               w_start = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Header emission; configuration is only sampled here.
      if (w_start) begin
         w_data_nxt  = DW_OUT'({HDR_TAG, r_seq});
         w_vld_nxt   = 1'b1;
         w_len_nxt   = rf_pkt_data_length;
         w_idle_nxt  = rf_pkt_idle_length;
         w_cnt_nxt   = '0;
         w_csum_nxt  = '0;
         w_state_nxt = ST_DATA_HI;
      end
   end

   always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
      if (pktctrl_rst) r_state <= ST_IDLE;
      else             r_state <= w_state_nxt;
   end

   always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
      if (pktctrl_rst) begin
         r_data <= '0;
         r_vld  <= 1'b0;
         r_done <= 1'b0;
         r_seq  <= '0;
         r_csum <= '0;
         r_cnt  <= '0;
         r_gap  <= '0;
         r_lo   <= '0;
         r_len  <= '0;
         r_idle <= '0;
      end else begin
         r_data <= w_data_nxt;
         r_vld  <= w_vld_nxt;
         r_done <= w_done_nxt;
         r_seq  <= w_seq_nxt;
         r_csum <= w_csum_nxt;
         r_cnt  <= w_cnt_nxt;
         r_gap  <= w_gap_nxt;
         r_lo   <= w_lo_nxt;
         r_len  <= w_len_nxt;
         r_idle <= w_idle_nxt;
      end
   end

endmodule

// File: tb/tb_adc_pkt_framer.sv
// tb_adc_pkt_framer
//   Directed bench for adc_pkt_framer with LEN_BASE=4. Outputs are sampled
//   on the falling edge into a short trace and checked against expected
//   beats built from the word list fed to the design.
module tb_adc_pkt_framer;

   logic        pktctrl_clk;
   logic        pktctrl_rst;
   logic        rf_pkt_en;
   logic [1:0]  rf_pkt_data_length;
   logic [15:0] rf_pkt_idle_length;
   logic [35:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] ADC_DATA;
   logic        ADC_DATA_VALID;
   logic        pkt_busy;
   logic        pkt_done;

   adc_pkt_framer #(.DW_IN(36), .DW_OUT(18), .LEN_BASE(4)) dut (
      .pktctrl_clk        (pktctrl_clk),
      .pktctrl_rst        (pktctrl_rst),
      .rf_pkt_en          (rf_pkt_en),
      .rf_pkt_data_length (rf_pkt_data_length),
      .rf_pkt_idle_length (rf_pkt_idle_length),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .ADC_DATA           (ADC_DATA),
      .ADC_DATA_VALID     (ADC_DATA_VALID),
      .pkt_busy           (pkt_busy),
      .pkt_done           (pkt_done)
   );

   initial pktctrl_clk = 1'b0;
   always #5 pktctrl_clk = ~pktctrl_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- source driver ----------------
   logic [35:0] src_q[$];
   logic [35:0] wl[$];
   int          acc_cnt = 0;
   bit          bp_mode = 0;

   initial begin
      bit pend;
      int cyc;
      pend = 0;
      cyc = 0;
      in_valid = 1'b0;
      in_data = '0;
      forever begin
         @(negedge pktctrl_clk);
         if (pend && src_q.size() > 0) begin
            void'(src_q.pop_front());
            acc_cnt++;
         end
         cyc++;
         // backpressure pattern per cycle: 1,0,0,1
         in_valid = (src_q.size() > 0) && (!bp_mode || (cyc % 4 == 0) || (cyc % 4 == 3));
         in_data  = (src_q.size() > 0) ? src_q[0] : '0;
         pend     = in_valid && in_ready;
      end
   end

   // ---------------- trace capture ----------------
   logic [17:0] t_dat [64];
   logic        t_vld [64];
   logic        t_done[64];
   logic        t_busy[64];
   logic        t_rdy [64];

   task automatic cap(input int n, input int drop_n);
      int base;
      base = acc_cnt;
      for (int i = 0; i < n; i++) begin
         @(negedge pktctrl_clk);
         t_dat[i]  = ADC_DATA;
         t_vld[i]  = ADC_DATA_VALID;
         t_done[i] = pkt_done;
         t_busy[i] = pkt_busy;
         t_rdy[i]  = in_ready;
         if (drop_n > 0 && (acc_cnt - base) >= drop_n) rf_pkt_en = 1'b0;
      end
   endtask

   function automatic int nvld(input int a, input int b);
      int c;
      c = 0;
      for (int i = a; i <= b; i++) if (t_vld[i] === 1'b1) c++;
      return c;
   endfunction

   function automatic int ndone(input int a, input int b);
      int c;
      c = 0;
      for (int i = a; i <= b; i++) if (t_done[i] === 1'b1) c++;
      return c;
   endfunction

   function automatic logic [17:0] csum_of(input int first, input int n);
      logic [17:0] c;
      c = '0;
      for (int i = first; i < first + n; i++) c = c ^ wl[i][35:18] ^ wl[i][17:0];
      return c;
   endfunction

   task automatic do_reset();
      @(posedge pktctrl_clk);
      #2;
      pktctrl_rst = 1'b1;
      rf_pkt_en   = 1'b0;
      bp_mode     = 0;
      src_q.delete();
      wl.delete();
      @(posedge pktctrl_clk);
      @(posedge pktctrl_clk);
      #2;
      pktctrl_rst = 1'b0;
   endtask

   task automatic load(input int n);
      logic [35:0] w;
      for (int i = 0; i < n; i++) begin
         case (wl.size())
            0: w = 36'h123456789;
            1: w = 36'h0AAAA5555;
            2: w = 36'hFFFFC0003;
            3: w = 36'h000012345;
            default: w = {4'($urandom_range(15)), 32'($urandom)};
         endcase
         wl.push_back(w);
         src_q.push_back(w);
      end
   endtask

   initial begin
      int k;
      int nb;
      int bad;
      int vb_i[10];
      logic [17:0] vb_d[10];

      pktctrl_rst = 1'b1;
      rf_pkt_en = 1'b0;
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd0;

      // ---- reset state, before any clock edge ----
      #3;
      chk("rst_data",  ADC_DATA, 18'h0);
      chk("rst_valid", ADC_DATA_VALID, 1'b0);
      chk("rst_done",  pkt_done, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_busy",  pkt_busy, 1'b0);

      // ---- 1: basic packet, len code 0 (4 words), idle 3 ----
      do_reset();
      load(8);
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd3;
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      cap(16, 0);
      chk("t1_hdr", {t_vld[0], t_dat[0]}, {1'b1, 18'h20000});
      chk("t1_hi0", t_dat[1], 18'h048D1);   // 0x123456789[35:18]
      chk("t1_lo0", t_dat[2], 18'h16789);   // 0x123456789[17:0]
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_hi%0d", i), t_dat[1+2*i], wl[i][35:18]);
         chk($sformatf("t1_lo%0d", i), t_dat[2+2*i], wl[i][17:0]);
      end
      chk("t1_pay_vld", nvld(1, 8), 8);
      chk("t1_trl", {t_vld[9], t_dat[9]}, {1'b1, csum_of(0, 4)});
      chk("t1_done", t_done[9], 1'b1);
      chk("t1_done_cnt", ndone(0, 12), 1);
      chk("t1_gap_vld", nvld(10, 12), 0);
      chk("t1_gap_dat", t_dat[11], 18'h0);
      chk("t1_hdr2", {t_vld[13], t_dat[13]}, {1'b1, 18'h20001});

      // ---- 2: backpressure ----
      do_reset();
      load(8);
      bp_mode = 1;
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd2;
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      cap(48, 0);
      nb = 0;
      for (int i = 0; i < 48; i++) begin
         if (t_vld[i] === 1'b1 && nb < 10) begin
            vb_i[nb] = i;
            vb_d[nb] = t_dat[i];
            nb++;
         end
      end
      chk("t2_nbeats", nb, 10);
      if (nb == 10) begin
         chk("t2_hdr", vb_d[0], 18'h20000);
         bad = 0;
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_hi%0d", i), vb_d[1+2*i], wl[i][35:18]);
            chk($sformatf("t2_lo%0d", i), vb_d[2+2*i], wl[i][17:0]);
            if (vb_i[2+2*i] != vb_i[1+2*i] + 1) bad++;
         end
         chk("t2_lo_follows_hi", bad, 0);
         chk("t2_trl", vb_d[9], csum_of(0, 4));
         chk("t2_trl_done", t_done[vb_i[9]], 1'b1);
         chk("t2_bubbles_seen", (vb_i[9] - vb_i[0]) > 9, 1'b1);
         bad = 0;
         for (int i = vb_i[0]; i <= vb_i[9]; i++)
            if (t_vld[i] !== 1'b1 && t_rdy[i] !== 1'b1) bad++;
         chk("t2_bubble_in_hi", bad, 0);
      end

      // ---- 3: back-to-back, len code 1 (8 words), idle 0 ----
      do_reset();
      load(16);
      rf_pkt_data_length = 2'd1;
      rf_pkt_idle_length = 16'd0;
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      cap(20, 0);
      chk("t3_hdr", {t_vld[0], t_dat[0]}, {1'b1, 18'h20000});
      chk("t3_pay_vld", nvld(1, 16), 16);
      chk("t3_no_early_done", ndone(0, 16), 0);
      chk("t3_trl", {t_vld[17], t_done[17], t_dat[17]}, {1'b1, 1'b1, csum_of(0, 8)});
      chk("t3_hdr2", {t_vld[18], t_dat[18]}, {1'b1, 18'h20001});
      chk("t3_busy", t_busy[18], 1'b1);

      // ---- 4: enable dropped after 2nd word ----
      do_reset();
      load(4);
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd2;
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      cap(16, 2);
      chk("t4_en_dropped", rf_pkt_en, 1'b0);
      chk("t4_pay_vld", nvld(1, 8), 8);
      chk("t4_trl", {t_vld[9], t_done[9], t_dat[9]}, {1'b1, 1'b1, csum_of(0, 4)});
      chk("t4_tail_quiet", nvld(10, 15), 0);
      chk("t4_gap_busy", t_busy[11], 1'b1);
      chk("t4_idle_busy", t_busy[12], 1'b0);
      load(4);
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      cap(2, 0);
      chk("t4_seq_cleared", {t_vld[0], t_dat[0]}, {1'b1, 18'h20000});

      // ---- 5: sequence wrap ----
      do_reset();
      load(8);
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd0;
      @(negedge pktctrl_clk);
      force dut.r_seq = 16'hFFFF;
      rf_pkt_en = 1'b1;
      @(negedge pktctrl_clk);
      chk("t5_hdr_ffff", {ADC_DATA_VALID, ADC_DATA}, {1'b1, 18'h2FFFF});
      release dut.r_seq;
      cap(12, 0);
      chk("t5_trl_done", t_done[8], 1'b1);
      chk("t5_hdr_wrap", {t_vld[9], t_dat[9]}, {1'b1, 18'h20000});

      // ---- 6: asynchronous reset in DATA_LO of the second packet ----
      do_reset();
      load(8);
      rf_pkt_data_length = 2'd0;
      rf_pkt_idle_length = 16'd0;
      @(negedge pktctrl_clk);
      rf_pkt_en = 1'b1;
      k = 0;
      while (pkt_done !== 1'b1 && k < 40) begin
         @(negedge pktctrl_clk);
         k++;
      end
      chk("t6_wait_done", k < 40, 1'b1);
      k = 0;
      while (!(in_ready === 1'b0 && ADC_DATA_VALID === 1'b1 && pkt_done === 1'b0) && k < 40) begin
         @(negedge pktctrl_clk);
         k++;
      end
      chk("t6_wait_lo", k < 40, 1'b1);
      #1;
      pktctrl_rst = 1'b1;
      #1;
      chk("t6_rst_data",  ADC_DATA, 18'h0);
      chk("t6_rst_valid", ADC_DATA_VALID, 1'b0);
      chk("t6_rst_ready", in_ready, 1'b0);
      chk("t6_rst_busy",  pkt_busy, 1'b0);
      src_q.delete();
      wl.delete();
      load(4);
      #1;
      pktctrl_rst = 1'b0;
      @(negedge pktctrl_clk);
      chk("t6_hdr_after", {ADC_DATA_VALID, ADC_DATA}, {1'b1, 18'h20000});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule
